// File: rtl/div16_seq_pkg.sv
// Shared definitions for the sequential divider: default width and FSM encodings.
package div16_seq_pkg;
  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/div16_seq_sub_step.sv
// One restoring-division trial subtraction, carried one bit wider than the operands.
module sub_step #(
  parameter int W = 17
) (
  input  logic [W-1:0] minuend,
  input  logic [W-1:0] subtrahend,
  output logic [W-1:0] difference,
  output logic         borrow
);
  logic [W:0] full;

  assign full       = {1'b0, minuend} - {1'b0, subtrahend};
  assign difference = full[W-1:0];
  assign borrow     = full[W];
endmodule

// File: rtl/div16_seq.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// Define SIGNED_DIV_EN to honour signed_op (two's-complement division).
module div16_seq
  import div16_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0] acc_q, acc_d;     // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             sgn_a, sgn_b;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;

`ifdef SIGNED_DIV_EN
  assign sgn_a   = signed_op & dividend[WIDTH-1];
  assign sgn_b   = signed_op & divisor[WIDTH-1];
  assign dvd_mag = sgn_a ? (~dividend + 1'b1) : dividend;
  assign dvs_mag = sgn_b ? (~divisor + 1'b1) : divisor;
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign sgn_a   = 1'b0;
  assign sgn_b   = 1'b0;
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  logic [WIDTH:0]   partial, diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_nxt, acc_nxt;
  logic             unused_diff_msb;

  assign partial = {rem_q, acc_q[WIDTH-1]};

  sub_step #(.W(WIDTH + 1)) u_step (
    .minuend    (partial),
    .subtrahend ({1'b0, dvs_q}),
    .difference (diff),
    .borrow     (borrow)
  );

  // Remainder stays below the divisor, so a successful trial never sets diff's MSB.
  assign unused_diff_msb = diff[WIDTH];
  assign rem_nxt = borrow ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
  assign acc_nxt = {acc_q[WIDTH-2:0], ~borrow};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        if (divisor == '0) begin
          quo_d   = '1;
          remo_d  = dividend;
          dbz_d   = 1'b1;
          state_d = DONE;
        end else begin
          rem_d   = '0;
          acc_d   = dvd_mag;
          dvs_d   = dvs_mag;
          negq_d  = sgn_a ^ sgn_b;
          negr_d  = sgn_a;
          cnt_d   = '0;
          dbz_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d = rem_nxt;
        acc_d = acc_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          quo_d   = negq_q ? (~acc_nxt + 1'b1) : acc_nxt;
          remo_d  = negr_q ? (~rem_nxt + 1'b1) : rem_nxt;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_div16_seq.sv
// Directed bench for div16_seq; latency is counted in clock edges after the start-sampling edge.
module tb_div16_seq;
  logic        clk = 1'b0;
  logic        rst_n, start, signed_op;
  logic [15:0] dividend, divisor, quotient, remainder;
  logic        busy, done, div_by_zero;
  int          n_cmp = 0;
  int          n_err = 0;
  int          lat, bcyc, pulses;
  logic [15:0] q_seen, r_seen;

  always #5 clk = ~clk;

  div16_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .signed_op  (signed_op),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge where done is seen.
  task automatic go(input logic [15:0] a, input logic [15:0] b, input logic s,
                    output int l, output int bc);
    start = 1'b1; dividend = a; divisor = b; signed_op = s;
    @(negedge clk);
    start = 1'b0; dividend = 16'hDEAD; divisor = 16'h0000; signed_op = ~s;
    l = 0; bc = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) bc++;
      if (done) break;
      l++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        output int l, output int bc);
    @(negedge clk);
    go(a, b, s, l, bc);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; signed_op = 1'b0;
    dividend = '0; divisor = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quo", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk); rst_n = 1'b1;

    run_op(16'd100, 16'd7, 1'b0, lat, bcyc);
    chk("u100_7_lat", lat, 16);
    chk("u100_7_busy", bcyc, 17);
    chk("u100_7_q", quotient, 14);
    chk("u100_7_r", remainder, 2);
    chk("u100_7_dbz", div_by_zero, 0);
    @(negedge clk);
    chk("pulse_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("hold_q", quotient, 14);

    run_op(16'h1234, 16'h0000, 1'b0, lat, bcyc);
    chk("dbz_lat", lat, 0);
    chk("dbz_q", quotient, 16'hFFFF);
    chk("dbz_r", remainder, 16'h1234);
    chk("dbz_flag", div_by_zero, 1);
    run_op(16'd10, 16'd2, 1'b0, lat, bcyc);
    chk("u10_2_dbz", div_by_zero, 0);
    chk("u10_2_q", quotient, 5);
    chk("u10_2_r", remainder, 0);

    // back-to-back: second start on the first IDLE cycle after done
    run_op(16'd1000, 16'd10, 1'b0, lat, bcyc);
    chk("b2b1_q", quotient, 100);
    chk("b2b1_r", remainder, 0);
    run_op(16'hFFFF, 16'd3, 1'b0, lat, bcyc);
    chk("b2b2_lat", lat, 16);
    chk("b2b2_q", quotient, 16'h5555);
    chk("b2b2_r", remainder, 0);

    // start re-pulsed mid-RUN with new operands
    @(negedge clk);
    start = 1'b1; dividend = 16'd100; divisor = 16'd7; signed_op = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 16'd200; divisor = 16'd3;
    @(negedge clk); start = 1'b0;
    pulses = 0; q_seen = '0; r_seen = '0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin pulses++; q_seen = quotient; r_seen = remainder; end
      @(negedge clk);
    end
    chk("repulse_cnt", pulses, 1);
    chk("repulse_q", q_seen, 14);
    chk("repulse_r", r_seen, 2);

    // reset at RUN cycle 8, then restart on the first edge after release
    start = 1'b1; dividend = 16'h4321; divisor = 16'd5;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_q", quotient, 0);
    chk("midrst_r", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    go(16'hFFFF, 16'h00FF, 1'b0, lat, bcyc);
    chk("postrst_lat", lat, 16);
    chk("postrst_q", quotient, 16'h0101);
    chk("postrst_r", remainder, 0);

    run_op(16'hFFF9, 16'd2, 1'b0, lat, bcyc);
    chk("u_fff9_2_q", quotient, 16'h7FFC);
    chk("u_fff9_2_r", remainder, 1);

`ifdef SIGNED_DIV_EN
    run_op(16'hFFF9, 16'd2, 1'b1, lat, bcyc);
    chk("s_m7_2_lat", lat, 16);
    chk("s_m7_2_q", quotient, 16'hFFFD);
    chk("s_m7_2_r", remainder, 16'hFFFF);
    run_op(16'd7, 16'hFFFE, 1'b1, lat, bcyc);
    chk("s_7_m2_q", quotient, 16'hFFFD);
    chk("s_7_m2_r", remainder, 1);
    run_op(16'h8000, 16'hFFFF, 1'b1, lat, bcyc);
    chk("s_min_m1_q", quotient, 16'h8000);
    chk("s_min_m1_r", remainder, 0);
`else
    run_op(16'hFFF9, 16'd2, 1'b1, lat, bcyc);
    chk("nosgn_lat", lat, 16);
    chk("nosgn_q", quotient, 16'h7FFC);
    chk("nosgn_r", remainder, 1);
    run_op(16'h8000, 16'hFFFF, 1'b1, lat, bcyc);
    chk("nosgn_min_q", quotient, 0);
    chk("nosgn_min_r", remainder, 16'h8000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
